// File: rtl/music_pkg.sv
// Shared constants and FSM state type for the music sequencer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package music_pkg;

  localparam int NOTE_W = 5;
  localparam int DUR_W  = 3;

  localparam logic [NOTE_W-1:0] NOTE_REST = 5'd0;
  localparam logic [NOTE_W-1:0] NOTE_END  = 5'd31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    PLAY  = 2'd3
  } state_t;

endpackage

// File: rtl/music_sequencer_beat_timer.sv
// Beat timer: one-cycle tick every BEAT_DIV enabled cycles.
// Latency: first tick BEAT_DIV cycles after clear; tick is combinational from the count.
// Backpressure: hold freezes the count and masks the tick; clear restarts from zero.
module beat_timer #(
  parameter int BEAT_DIV = 12500000
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic hold,
  output logic tick
);

  localparam int CNT_W = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BEAT_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = !clear && !hold && (cnt == CNT_MAX);

  // Beat-phase counter; a clear takes precedence so a new note always starts on a fresh beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else if (!hold) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/music_sequencer.sv
// Score sequencer: walks a synchronous score ROM and drives note codes; optional SFX override (SFX_OVERRIDE_EN).
// Latency: 2 silent cycles (FETCH, LOAD) per entry, then (dur+1)*BEAT_DIV cycles of note; outputs registered.
// Backpressure: an active sound-effect request freezes the FSM and beat timer until released.
module music_sequencer
  import music_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int BEAT_DIV = 12500000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  input  logic              sfx_req,
  input  logic [4:0]        sfx_note,
  output logic              sfx_ack,
  output logic [4:0]        note_code,
  output logic              busy
);

  localparam logic [DUR_W:0] ONE_BEAT = 1;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [DUR_W:0]      beats_left, beats_nxt;
  logic [NOTE_W-1:0]   score_note, score_nxt;
  logic                timer_clear;
  logic                timer_hold;
  logic                tick;
  logic                sfx_active;
  logic                freeze;

`ifdef SFX_OVERRIDE_EN
  assign sfx_active = sfx_req;
`else
  // Sound effects compiled out: the ports stay for pin compatibility only.
  logic unused_sfx;
  assign unused_sfx = ^{sfx_req, sfx_note};
  assign sfx_active = 1'b0;
`endif

  // start/stop act even while a sound effect owns the output.
  assign freeze     = sfx_active && !stop && !start;
  assign timer_hold = freeze || (state != PLAY);

  beat_timer #(
    .BEAT_DIV (BEAT_DIV)
  ) u_beat_timer (
    .clk   (clk),
    .rstn  (rstn),
    .clear (timer_clear),
    .hold  (timer_hold),
    .tick  (tick)
  );

  // Next-state and datapath decode; stop beats start, both beat the SFX freeze.
  always_comb begin
    state_nxt   = state;
    addr_nxt    = rom_addr;
    beats_nxt   = beats_left;
    score_nxt   = score_note;
    timer_clear = 1'b0;
    if (stop) begin
      state_nxt   = IDLE;
      addr_nxt    = '0;
      beats_nxt   = '0;
      score_nxt   = NOTE_REST;
      timer_clear = 1'b1;
    end else if (start) begin
      state_nxt   = FETCH;
      addr_nxt    = '0;
      beats_nxt   = '0;
      score_nxt   = NOTE_REST;
      timer_clear = 1'b1;
    end else if (!freeze) begin
      case (state)
        IDLE:  state_nxt = IDLE;
        FETCH: state_nxt = LOAD;
        LOAD: begin
          if (rom_data[7:3] == NOTE_END) begin
            if (loop_en) begin
              state_nxt = FETCH;
              addr_nxt  = '0;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            state_nxt   = PLAY;
            beats_nxt   = {1'b0, rom_data[DUR_W-1:0]} + ONE_BEAT;
            score_nxt   = rom_data[7:3];
            timer_clear = 1'b1;
          end
        end
        PLAY: begin
          if (tick) begin
            if (beats_left == ONE_BEAT) begin
              state_nxt = FETCH;
              addr_nxt  = rom_addr + ADDR_W'(1);
              beats_nxt = '0;
              score_nxt = NOTE_REST;
            end else begin
              beats_nxt = beats_left - ONE_BEAT;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State, score registers and registered outputs; the SFX note bypasses the score note.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      rom_addr   <= '0;
      beats_left <= '0;
      score_note <= NOTE_REST;
      note_code  <= NOTE_REST;
      busy       <= 1'b0;
      sfx_ack    <= 1'b0;
    end else begin
      state      <= state_nxt;
      rom_addr   <= addr_nxt;
      beats_left <= beats_nxt;
      score_note <= score_nxt;
      note_code  <= sfx_active ? sfx_note : score_nxt;
      busy       <= (state_nxt != IDLE);
      sfx_ack    <= sfx_active;
    end
  end

endmodule

// File: doc/music_sequencer.md
MUSIC_SEQUENCER -- requirements
Module: music_sequencer

Interface
REQ-001 Parameter: ADDR_W, default 8, score memory address width.
REQ-002 Parameter: BEAT_DIV, default 12500000, clk cycles per beat unit (1/8 s at 100 MHz); legal range is 2 or more.
REQ-003 Port: clk  in  1  single clock, all logic rising-edge.
REQ-004 Port: rstn  in  1  reset, asynchronous, active-low.
REQ-005 Port: start  in  1  one-cycle pulse: play score from address 0.
REQ-006 Port: stop  in  1  one-cycle pulse: abort playback.
REQ-007 Port: loop_en  in  1  level: at end-of-score, restart from address 0.
REQ-008 Port: rom_addr  out  ADDR_W  score memory address, registered.
REQ-009 Port: rom_data  in  8  score entry; [7:3] note code, [2:0] duration code; valid one cycle after rom_addr changes (synchronous ROM).
REQ-010 Port: sfx_req  in  1  level: sound-effect request.
REQ-011 Port: sfx_note  in  5  sound-effect note code.
REQ-012 Port: sfx_ack  out  1  registered: sound effect currently owns note_code.
REQ-013 Port: note_code  out  5  registered note code to the music decoder; 0 = silence.
REQ-014 Port: busy  out  1  registered: sequencer not IDLE.

Function
REQ-015 FSM states: IDLE, FETCH, LOAD, PLAY.
REQ-016 IDLE: note_code=0 (when no sfx), busy=0; start -> FETCH with rom_addr=0.
REQ-017 FETCH (1 cycle): rom_addr stable, note_code=0 -> LOAD.
REQ-018 LOAD (1 cycle): sample rom_data; note field 31 = end marker; otherwise load beats_left=dur+1, clear tick counter -> PLAY.
REQ-019 End marker with loop_en=1: rom_addr=0 -> FETCH; with loop_en=0: -> IDLE, busy=0 next cycle.
REQ-020 PLAY: note_code = sampled note field (code 0 is a rest); tick every BEAT_DIV cycles; beats_left decrements per tick; the tick taking it to 0 -> rom_addr+1, FETCH.
REQ-021 Note length in PLAY is exactly (dur+1)*BEAT_DIV cycles; each entry adds 2 silent cycles (FETCH, LOAD).
REQ-022 rom_addr wraps from 2^ADDR_W-1 to 0 without an end marker; no error flag.
REQ-023 stop in any state -> IDLE, rom_addr=0, note_code=0 next cycle.
REQ-024 start while busy: restart at FETCH, rom_addr=0; start and stop in the same cycle: stop wins.
REQ-025 Sfx arbitration: sfx has priority over the score. While sfx_req=1, next cycle sfx_ack=1, note_code=sfx_note (tracks sfx_note each cycle), FSM, tick counter and beats_left frozen.
REQ-026 sfx_req falling: next cycle sfx_ack=0 and the score resumes in the frozen state with the remaining time intact; in IDLE, note_code returns to 0.
REQ-027 stop/start during sfx: FSM action applies immediately; sfx keeps note_code ownership until sfx_req=0.

Reset
REQ-028 rstn low: state=IDLE, rom_addr=0, note_code=0, busy=0, sfx_ack=0, tick counter=0, beats_left=0, asynchronously; release is synchronous to clk.

Configuration
REQ-029 Macro SFX_OVERRIDE_EN defined: REQ-025 to REQ-027 active.
REQ-030 Macro SFX_OVERRIDE_EN undefined: sfx_req and sfx_note ignored, sfx_ack tied 0, ports retained.

Structure
REQ-031 Package music_pkg holds: NOTE_REST=0, NOTE_END=31, NOTE_W=5, DUR_W=3, FSM state typedef.
REQ-032 Sub-module beat_timer (BEAT_DIV parameter; clear and hold inputs; one-cycle tick output) generates ticks.

Verification (BEAT_DIV=4)
REQ-033 Score {note 8, dur 1},{END}; start pulse; loop_en=0 -> note_code=8 for exactly 8 cycles, then 0; busy falls 3 cycles after PLAY ends.
REQ-034 Score {12,0},{END}; loop_en=1 -> pattern 12 x4 cycles, 0 x2 (end-marker FETCH, LOAD), 0 x2 (FETCH, LOAD of address 0), repeating; busy stays 1.
REQ-035 Playing {8,3}; sfx_req high 5 cycles at PLAY cycle 6, sfx_note=20 -> note_code=20 for 5 cycles, then 8 for the remaining 10 cycles (16 total).
REQ-036 stop pulse mid-note -> next cycle note_code=0, busy=0, rom_addr=0; start and stop together -> IDLE.
REQ-037 rstn asserted mid-PLAY -> all outputs 0 without a clock edge.
REQ-038 Build without SFX_OVERRIDE_EN; sfx_req=1 -> sfx_ack=0, note timing unchanged.
